pc_redirect_ctrl: RTL and testbench

//  Sequencer for the fetch PC register in the 5-stage pipelined CPU. Each cycle it selects
//  the next PC: sequential, ID-stage jump (j/jal/jr/jalr) or EX-stage taken branch. It raises
//  the IF/ID and ID/EX flush strobes and gates the PC write enable on hazard stalls and

---
 rtl/pc_redirect_ctrl.sv | 89 ++++++++
 tb/tb_pc_redirect_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: selects next fetch PC, raises pipeline flushes and holds branches blocked by fetch wait
module pc_redirect_ctrl #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             imem_wait,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_req,
    input  logic [WIDTH-1:0] jmp_target,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_next,
    output logic             flush_if,
    output logic             flush_id,
    output logic             redirect_busy,
    output logic [CNT_W-1:0] redirect_cnt
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redir;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        pc_en     = !stall && !imem_wait;
        pc_next   = pc + WIDTH'(4);
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        redir     = 1'b0;
        if (rst) begin
            pc_en    = 1'b1;
            pc_next  = RESET_PC;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (state_q == PEND) begin
            // jumps seen here are wrong-path; only a newer branch can replace the held target
            flush_if = 1'b1;
            flush_id = br_req;
            if (imem_wait) begin
                pc_en     = 1'b0;
                pend_pc_d = br_req ? br_target : pend_pc_q;
            end else begin
                pc_en   = 1'b1;
                pc_next = br_req ? br_target : pend_pc_q;
                state_d = RUN;
                redir   = 1'b1;
            end
        end else if (br_req) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            pc_en    = !imem_wait;
            pc_next  = br_target;
            redir    = !imem_wait;
            if (imem_wait) begin
                pend_pc_d = br_target;
                state_d   = PEND;
            end
        end else if (jmp_req && !stall && !imem_wait) begin
            pc_next  = jmp_target;
            flush_if = 1'b1;
            redir    = 1'b1;
        end
        cnt_d = (redir && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign redirect_busy = (state_q == PEND);
    assign redirect_cnt  = cnt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vectors checked every cycle against a priority-rule model
module tb_pc_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, imem_wait = 1'b0, br_req = 1'b0, jmp_req = 1'b0;
    logic [31:0] pc = '0, br_target = '0, jmp_target = '0;
    logic        pc_en, flush_if, flush_id, redirect_busy;
    logic [31:0] pc_next;
    logic [15:0] redirect_cnt;
    int          total = 0, bad = 0;

    bit          m_pend = 0;
    logic [31:0] m_pc = '0;
    int          m_cnt = 0;

    pc_redirect_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall), .imem_wait(imem_wait),
        .br_req(br_req), .br_target(br_target), .jmp_req(jmp_req), .jmp_target(jmp_target),
        .pc_en(pc_en), .pc_next(pc_next), .flush_if(flush_if), .flush_id(flush_id),
        .redirect_busy(redirect_busy), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected combinational outputs from the priority rules; apply=1 when a redirect takes effect
    task automatic model(output bit en, output logic [31:0] nxt, output bit fi, output bit fd,
                         output bit apply);
        apply = 0;
        en = !stall && !imem_wait; nxt = pc + 32'd4; fi = 0; fd = 0;
        if (rst) begin
            en = 1; nxt = 32'h0; fi = 1; fd = 1;
        end else if (m_pend) begin
            fi = 1; fd = br_req; en = !imem_wait; apply = !imem_wait;
            nxt = br_req ? br_target : m_pc;
        end else if (br_req) begin
            fi = 1; fd = 1; en = !imem_wait; apply = !imem_wait; nxt = br_target;
        end else if (jmp_req && !stall && !imem_wait) begin
            en = 1; fi = 1; apply = 1; nxt = jmp_target;
        end
    endtask

    always @(posedge clk) begin
        bit en, fi, fd, ap;
        logic [31:0] nx;
        model(en, nx, fi, fd, ap);
        if (rst) begin
            m_pend = 0; m_pc = '0; m_cnt = 0;
        end else begin
            if (ap && m_cnt < 65535) m_cnt++;
            if (m_pend) begin
                if (imem_wait && br_req) m_pc = br_target;
                if (!imem_wait) m_pend = 0;
            end else if (br_req && imem_wait) begin
                m_pend = 1; m_pc = br_target;
            end
        end
    end

    always @(negedge clk) begin
        bit en, fi, fd, ap;
        logic [31:0] nx;
        model(en, nx, fi, fd, ap);
        chk("pc_en", pc_en, en);
        if (en) chk("pc_next", pc_next, nx);
        chk("flush_if", flush_if, fi);
        chk("flush_id", flush_id, fd);
        chk("busy", redirect_busy, m_pend);
        chk("cnt", redirect_cnt, m_cnt);
    end

    task automatic step(input bit r, input bit s, input bit w, input bit b, input bit j,
                        input logic [31:0] p, input logic [31:0] bt, input logic [31:0] jt);
        @(posedge clk); #1;
        rst = r; stall = s; imem_wait = w; br_req = b; jmp_req = j;
        pc = p; br_target = bt; jmp_target = jt;
        @(negedge clk); #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0, 0);
        chk("t1_rst_next", pc_next, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0);
        chk("t1_next", pc_next, 32'h4);
        chk("t1_en", pc_en, 1);
        chk("t1_cnt", redirect_cnt, 0);
        step(0, 1, 0, 0, 0, 32'h40, 0, 0);
        chk("t2_stall_en", pc_en, 0);
        step(0, 1, 0, 1, 0, 32'h40, 32'h80, 0);
        chk("t2_br_next", pc_next, 32'h80);
        chk("t2_br_flush", {pc_en, flush_if, flush_id}, 3'b111);
        step(0, 0, 1, 1, 0, 32'h100, 32'h200, 0);
        chk("t2_cnt", redirect_cnt, 1);
        chk("t3_cap_en", pc_en, 0);
        step(0, 0, 1, 0, 0, 32'h100, 0, 0);
        chk("t3_busy", redirect_busy, 1);
        step(0, 0, 1, 0, 0, 32'h100, 0, 0);
        step(0, 0, 0, 0, 0, 32'h100, 0, 0);
        chk("t3_apply_next", pc_next, 32'h200);
        chk("t3_apply_en", pc_en, 1);
        step(0, 0, 0, 0, 0, 32'h200, 0, 0);
        chk("t3_busy_clr", redirect_busy, 0);
        chk("t3_cnt", redirect_cnt, 2);
        step(0, 0, 0, 1, 1, 32'h300, 32'h500, 32'h3000);
        chk("t4_br_wins", pc_next, 32'h500);
        chk("t4_fid", flush_id, 1);
        step(0, 1, 0, 0, 1, 32'h500, 0, 32'h3000);
        chk("t4_jstall", {pc_en, flush_if, flush_id}, 3'b000);
        step(0, 0, 0, 0, 1, 32'h500, 0, 32'h3000);
        chk("t4_jmp", {pc_next, flush_if, flush_id}, {32'h3000, 2'b10});
        step(0, 0, 1, 1, 0, 32'h3000, 32'h600, 0);
        step(0, 0, 1, 1, 0, 32'h3000, 32'h700, 0);
        chk("t4_pend_over_fid", flush_id, 1);
        step(0, 1, 0, 0, 1, 32'h3000, 0, 32'h3000);
        chk("t4_newest", pc_next, 32'h700);
        step(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        chk("t4_cnt", redirect_cnt, 5);
        chk("t5_wrap", pc_next, 32'h0);
        step(0, 0, 1, 1, 0, 32'h20, 32'h900, 0);
        step(1, 0, 1, 0, 0, 32'h20, 0, 0);
        chk("t5_busy_pre", redirect_busy, 1);
        step(0, 0, 0, 0, 0, 32'h10, 0, 0);
        chk("t5_busy_rst", redirect_busy, 0);
        chk("t5_discard", pc_next, 32'h14);
        chk("t5_cnt_rst", redirect_cnt, 0);
        for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 1, 32'h0, 0, 32'h1000);
        step(0, 0, 0, 0, 1, 32'h0, 0, 32'h1000);
        chk("t6_full", redirect_cnt, 16'hFFFF);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0);
        chk("t6_sat", redirect_cnt, 16'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
